// File: rtl/seq_addsub_n_if.sv
// Handshake and operand/result bundle for seq_addsub_n.
// The master modport is the producer/consumer side and the slave modport is the adder.
interface seq_addsub_n_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             C_msb;
  logic             ovf;

  modport master (
    output in_valid, A, B, Cin, sub, acc, out_ready,
    input  in_ready, out_valid, S, cout, C_msb, ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, sub, acc, out_ready,
    output in_ready, out_valid, S, cout, C_msb, ovf
  );
endinterface

// File: rtl/seq_addsub_n.sv
// Sequential adder/subtractor that sums CHUNK bits per cycle, LSB slice first.
// Optional accumulate mode (operand A replaced by the S register) is built with SEQ_ADDSUB_ACCUM_EN.
module seq_addsub_n #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic         clk,
  input logic         rst,
  seq_addsub_n_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] part;
  logic             carry;
  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;
  logic             cmsb_reg;
  logic             ovf_reg;
  logic             last;
  logic [CHUNK:0]   slice;
  logic [WIDTH-1:0] full;
  logic             accept;
  logic             in_ready_c;
  logic             out_valid_c;

`ifndef SEQ_ADDSUB_ACCUM_EN
  logic unused_acc;
  assign unused_acc = bus.acc;
`endif

  // Current slice sum plus the partial result with that slice merged in.
  always_comb begin
    last  = (idx == IW'(N - 1));
    slice = {1'b0, a_reg[int'(idx)*CHUNK +: CHUNK]}
          + {1'b0, b_reg[int'(idx)*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, carry};
    full  = part;
    full[int'(idx)*CHUNK +: CHUNK] = slice[CHUNK-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_next = CALC;
      end
      CALC: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept        = in_ready_c && bus.in_valid;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;

  // Subtraction is folded in at capture: B is inverted and the +1 rides in as the first carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      part     <= '0;
      carry    <= 1'b0;
      s_reg    <= '0;
      cout_reg <= 1'b0;
      cmsb_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (accept) begin
`ifdef SEQ_ADDSUB_ACCUM_EN
      a_reg <= bus.acc ? s_reg : bus.A;
`else
      a_reg <= bus.A;
`endif
      b_reg <= bus.sub ? ~bus.B : bus.B;
      carry <= bus.sub ? 1'b1 : bus.Cin;
      idx   <= '0;
      part  <= '0;
    end else if (state == CALC) begin
      part  <= full;
      carry <= slice[CHUNK];
      if (last) begin
        idx      <= '0;
        s_reg    <= full;
        cout_reg <= slice[CHUNK];
        cmsb_reg <= full[WIDTH-1] ^ a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
        ovf_reg  <= slice[CHUNK] ^ (full[WIDTH-1] ^ a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign bus.S     = s_reg;
  assign bus.cout  = cout_reg;
  assign bus.C_msb = cmsb_reg;
  assign bus.ovf   = ovf_reg;
endmodule
